// File: rtl/alu_muldiv_unit.sv
// EX-stage execute unit: registered single-cycle ALU/shift ops plus iterative MUL/DIV into HI/LO.
// Optional `ALU_OVF_EN adds a registered signed-overflow flag (ovf) for ADD/SUB.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             ZeroFlag,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

    state_t             state_reg, state_next;
    logic [SHW:0]       cnt_reg;
    logic [WIDTH-1:0]   opa_reg, opb_reg, acc_hi_reg, acc_lo_reg;
    logic               sa_reg, sb_reg, is_div_reg;

    logic [WIDTH-1:0]   sum, diff, alu_res, abs_a, abs_b;
    logic               alu_ill, is_muldiv, is_signed;
`ifdef ALU_OVF_EN
    logic               alu_ovf;
`endif

    assign sum       = A + B;
    assign diff      = A - B;
    assign in_ready  = (state_reg == IDLE);
    assign is_signed = ~ALUControl[0];
    assign abs_a     = (is_signed & A[WIDTH-1]) ? -A : A;
    assign abs_b     = (is_signed & B[WIDTH-1]) ? -B : B;

    always_comb begin
        alu_res   = '0;
        alu_ill   = 1'b0;
        is_muldiv = 1'b0;
`ifdef ALU_OVF_EN
        alu_ovf   = 1'b0;
`endif
        case (ALUControl)
            6'b100000: begin
                alu_res = sum;
`ifdef ALU_OVF_EN
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`endif
            end
            6'b100001: alu_res = sum;
            6'b100010: begin
                alu_res = diff;
`ifdef ALU_OVF_EN
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
`endif
            end
            6'b100011: alu_res = diff;
            6'b100100: alu_res = A & B;
            6'b100101: alu_res = A | B;
            6'b100110: alu_res = A ^ B;
            6'b100111: alu_res = ~(A | B);
            6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            6'b101011: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            6'b000000: alu_res = B << shamt;
            6'b000010: alu_res = B >> shamt;
            6'b000011: alu_res = $unsigned($signed(B) >>> shamt);
            6'b000100: alu_res = B << A[SHW-1:0];
            6'b000110: alu_res = B >> A[SHW-1:0];
            6'b000111: alu_res = $unsigned($signed(B) >>> A[SHW-1:0]);
            6'b010000: alu_res = hi;
            6'b010010: alu_res = lo;
            6'b010001, 6'b010011: alu_res = A;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: is_muldiv = 1'b1;
            default:   alu_ill = 1'b1;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opa_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_reg};
        if (is_div_reg) begin
            if (div_shift >= {1'b0, opb_reg}) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    always_comb begin
        prod     = {acc_hi_reg, acc_lo_reg};
        prod_fix = (sa_reg ^ sb_reg) ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (opb_reg == '0) begin
                // Divide by zero: quotient all ones, remainder is the original dividend.
                fix_lo = '1;
                fix_hi = sa_reg ? -opa_reg : opa_reg;
            end else begin
                fix_lo = (sa_reg ^ sb_reg) ? -acc_lo_reg : acc_lo_reg;
                fix_hi = sa_reg ? -acc_hi_reg : acc_hi_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid && is_muldiv) state_next = RUN;
            RUN:     if (cnt_reg == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            is_div_reg <= 1'b0;
            result     <= '0;
            ZeroFlag   <= 1'b1;
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
`ifdef ALU_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                IDLE: if (in_valid) begin
                    if (is_muldiv) begin
                        opa_reg    <= abs_a;
                        opb_reg    <= abs_b;
                        sa_reg     <= is_signed & A[WIDTH-1];
                        sb_reg     <= is_signed & B[WIDTH-1];
                        is_div_reg <= ALUControl[1];
                        cnt_reg    <= '0;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= ALUControl[1] ? abs_a : abs_b;
                    end else begin
                        result    <= alu_res;
                        ZeroFlag  <= (alu_res == '0);
                        out_valid <= 1'b1;
                        illegal   <= alu_ill;
`ifdef ALU_OVF_EN
                        ovf       <= alu_ovf;
`endif
                        if (ALUControl == 6'b010001) hi <= A;
                        if (ALUControl == 6'b010011) lo <= A;
                    end
                end
                RUN: begin
                    cnt_reg    <= cnt_reg + 1'b1;
                    acc_hi_reg <= step_hi;
                    acc_lo_reg <= step_lo;
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    result    <= fix_lo;
                    ZeroFlag  <= (fix_lo == '0);
                    out_valid <= 1'b1;
                    illegal   <= 1'b0;
`ifdef ALU_OVF_EN
                    ovf       <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit (WIDTH=32); ovf checks only when ALU_OVF_EN is defined.
module tb_alu_muldiv_unit;
    logic        clk, reset, in_valid, in_ready, out_valid, ZeroFlag, illegal;
    logic [5:0]  ALUControl;
    logic [31:0] A, B, result, hi, lo;
    logic [4:0]  shamt;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif
    int errors = 0;
    int checks = 0;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .A(A), .B(B), .shamt(shamt),
        .out_valid(out_valid), .result(result), .ZeroFlag(ZeroFlag),
        .illegal(illegal), .hi(hi),
`ifdef ALU_OVF_EN
        .ovf(ovf),
`endif
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns #1 after the acceptance edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        in_valid = 1'b1; ALUControl = f; A = a; B = b; shamt = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        issue(f, a, b, sh);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check(tag, result, exp);
        check({tag, ".zero"}, {31'b0, ZeroFlag}, {31'b0, exp == 32'd0});
        $display("op %s f=%b A=%h B=%h sh=%0d -> result=%h", tag, f, a, b, sh, result);
    endtask

    task automatic multi(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n, low;
        issue(f, a, b, 5'd0);
        n = 1; low = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, n, 34);
        check({tag, ".busy"}, low, 33);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        check({tag, ".result"}, result, exp_lo);
        $display("op %s A=%h B=%h -> hi=%h lo=%h after %0d cycles", tag, a, b, hi, lo, n);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; in_valid = 1'b0; ALUControl = '0; A = '0; B = '0; shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'b0, ZeroFlag}, 32'd1);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        check("rst.ready", {31'b0, in_ready}, 32'd1);
        check("rst.valid", {31'b0, out_valid}, 32'd0);

        single("sra", 6'b000011, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        @(posedge clk); #1;
        check("sra.pulse", {31'b0, out_valid}, 32'd0);
        single("addu_wrap", 6'b100001, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
        single("sub", 6'b100010, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
        single("slt", 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        single("sltu", 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        single("nor", 6'b100111, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'hF0F0_FF0F);
        single("xor", 6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'hF0F0_F0F0);
        single("sll", 6'b000000, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000);
        single("sllv", 6'b000100, 32'd33, 32'd3, 5'd0, 32'd6);
        single("srlv", 6'b000110, 32'd4, 32'h8000_0000, 5'd0, 32'h0800_0000);
        single("srav", 6'b000111, 32'd8, 32'h8000_0000, 5'd0, 32'hFF80_0000);
        single("mthi", 6'b010001, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678);
        check("mthi.hi", hi, 32'h1234_5678);
        single("mtlo", 6'b010011, 32'h0BAD_F00D, 32'h0, 5'd0, 32'h0BAD_F00D);
        single("mflo", 6'b010010, 32'h0, 32'h0, 5'd0, 32'h0BAD_F00D);

        multi("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        @(posedge clk); #1;
        check("mult.pulse", {31'b0, out_valid}, 32'd0);
        single("mfhi", 6'b010000, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF);
        multi("multu", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        multi("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        multi("div_negdivisor", 6'b011010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        multi("divu_by0", 6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        check("divu_by0.zero", {31'b0, ZeroFlag}, 32'd0);
        multi("div_by0_neg", 6'b011010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        multi("div_minneg", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Requests while busy are dropped: only the DIVU completes.
        issue(6'b011011, 32'd100, 32'd7, 5'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALUControl = 6'b100000; A = 32'd1; B = 32'd1;
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("busy.pulses", pulses, 1);
        check("busy.lo", lo, 32'd14);
        check("busy.hi", hi, 32'd2);
        check("busy.result", result, 32'd14);
        $display("op busy_divu 100/7 with ADD poked -> pulses=%0d lo=%h hi=%h", pulses, lo, hi);

        // Asynchronous reset during RUN cycle 10.
        issue(6'b011001, 32'd3, 32'd4, 5'd0);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst.ready", {31'b0, in_ready}, 32'd1);
        check("midrst.hi", hi, 32'd0);
        check("midrst.lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("midrst.pulses", pulses, 0);
        $display("op reset_mid_multu -> hi=%h lo=%h pulses=%0d", hi, lo, pulses);

        single("mtlo2", 6'b010011, 32'h0000_0055, 32'h0, 5'd0, 32'h0000_0055);
        single("illegal", 6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'h0);
        check("illegal.flag", {31'b0, illegal}, 32'd1);
        check("illegal.lo", lo, 32'h0000_0055);
        single("and", 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000);
        check("and.illegal", {31'b0, illegal}, 32'd0);

`ifdef ALU_OVF_EN
        single("add_ovf", 6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
        check("add_ovf.ovf", {31'b0, ovf}, 32'd1);
        single("addu_noovf", 6'b100001, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
        check("addu_noovf.ovf", {31'b0, ovf}, 32'd0);
        single("sub_ovf", 6'b100010, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF);
        check("sub_ovf.ovf", {31'b0, ovf}, 32'd1);
`else
        single("add_wrap", 6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised multi-cycle execute unit; successor to the single-cycle combinational ALU.
- Keeps the full funct-coded ALU/shift operation set, with registered output.
- Adds iterative signed/unsigned multiply and divide writing HI/LO registers, plus MFHI/MFLO/MTHI/MTLO.
- Sits in the EX stage; valid/ready handshake so the controller stalls issue while a mul/div runs.

Parameters:
WIDTH, 32, operand/result width (even, >=8).
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept; = (state==IDLE).
ALUControl  input  6  MIPS funct code.
A  input  WIDTH  rs operand.
B  input  WIDTH  rt operand.
shamt  input  SHW  immediate shift amount.
out_valid  output  1  one-cycle pulse: result/ZeroFlag valid.
result  output  WIDTH  registered result.
ZeroFlag  output  1  registered (result==0).
illegal  output  1  registered; 1 with out_valid for an unsupported funct.
hi, lo  output  WIDTH each  architectural HI/LO.

Behaviour:
- Reset values: result=0, ZeroFlag=1, out_valid=0, illegal=0, hi=0, lo=0, state=IDLE, in_ready=1.
- Acceptance: rising edge with in_valid & in_ready. in_valid while busy is ignored (no queueing).
- No output back-pressure: out_valid is exactly one cycle.
- Single-cycle ops, latency 1 (out_valid in the cycle after acceptance):
  - ADD 100000, ADDU 100001: A+B. SUB 100010, SUBU 100011: A-B. Wrap mod 2^WIDTH.
  - AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SLT 101010: signed compare. SLTU 101011: unsigned compare. Result is 1 or 0.
  - SLL 000000, SRL 000010, SRA 000011: shift B by shamt.
  - SLLV 000100, SRLV 000110, SRAV 000111: shift B by A[SHW-1:0].
  - MFHI 010000: result=hi. MFLO 010010: result=lo.
  - MTHI 010001: hi<=A, result=A. MTLO 010011: lo<=A, result=A.
- Multi-cycle ops: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- FSM states IDLE, RUN, FIX:
  - IDLE -> RUN on acceptance.
    - Latch |A| and |B| for signed ops; raw operands for unsigned.
    - Latch sign flags; clear the iteration counter.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle, exactly WIDTH cycles. Counter is SHW+1 bits; leave RUN when counter==WIDTH-1.
  - FIX: one cycle. Apply sign correction, then go to IDLE. On that edge: hi/lo updated, result=lo, out_valid=1.
  - Total latency acceptance -> out_valid = WIDTH+2 cycles; in_ready low for WIDTH+1 cycles.
- Multiply: {hi,lo} = full 2*WIDTH product. Signed: negate if signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: lo=all ones, hi=A (dividend). No trap.
  - Signed most-negative / -1: lo=most-negative, hi=0.
- Unsupported funct: latency 1, result=0, ZeroFlag=1, illegal=1; hi/lo unchanged.
- ZeroFlag always reflects the registered result.
- Reset mid-operation: returns to IDLE at once. hi/lo return to 0; the partial operation is discarded; no out_valid.

Optional Feature:
ALU_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0), registered with out_valid.
  - ovf=1 on signed overflow of ADD/SUB; result still written (wrapped).
  - ovf=0 for all other ops, including ADDU/SUBU.
- Undefined: no ovf port; ADD/SUB behave exactly like ADDU/SUBU.

Test Plan:
1. Reset then idle -> result=0, ZeroFlag=1, hi=lo=0, in_ready=1. SRA with B=0x80000000, shamt=4 -> next cycle result=0xF8000000, out_valid 1 cycle.
2. MULT A=0xFFFFFFFD (-3), B=5 -> in_ready low 33 cycles; out_valid at cycle 34. hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MFHI -> 0xFFFFFFFF.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7, ZeroFlag=0.
4. Issue ADD while a DIVU is busy -> ignored, no extra out_valid. Reset asserted at RUN cycle 10 -> immediate IDLE, hi=lo=0, no out_valid.
5. ALU_OVF_EN defined: ADD 0x7FFFFFFF+1 -> result=0x80000000, ovf=1. ADDU same operands -> ovf=0. Funct 111111 -> illegal=1, result=0.
